// File: rtl/smc_pkg.sv
// Shared widths, mode bit positions and the transistor descriptor type
// for the smc_pipe current/transconductance receiver.
package smc_pkg;

    localparam int W_BITS         = 3;
    localparam int OUT_BITS       = 10;
    localparam int VAL_BITS       = 7;
    localparam int MODE_ID_BIT    = 0;
    localparam int MODE_LARGE_BIT = 1;
    localparam int N_XTOR         = 6;

    localparam logic [W_BITS-1:0] VTH = 3'd1;

    typedef struct packed {
        logic [W_BITS-1:0] w;
        logic [W_BITS-1:0] v_gs;
        logic [W_BITS-1:0] v_ds;
    } xtor_t;

endpackage

// File: rtl/smc_cell.sv
// Combinational per-transistor evaluator: returns I_D or g_m for one descriptor,
// choosing cutoff, triode or saturation from the overdrive.
module smc_cell
    import smc_pkg::*;
(
    input  xtor_t               xtor,
    input  logic                id_mode,
    output logic [VAL_BITS-1:0] val
);

    logic [9:0] w_x, gs_x, ds_x, ov_x, id_x, gm_x;

    // All arithmetic is done at 10 bits; the largest intermediate (W*ov^2) is 252.
    always_comb begin
        w_x  = 10'(xtor.w);
        gs_x = 10'(xtor.v_gs);
        ds_x = 10'(xtor.v_ds);
        ov_x = gs_x - 10'(VTH);
        id_x = '0;
        gm_x = '0;
        if (gs_x <= 10'(VTH)) begin
            id_x = '0;
            gm_x = '0;
        end else if (ov_x > ds_x) begin
            id_x = (w_x * (10'd2 * ov_x * ds_x - ds_x * ds_x)) / 10'd3;
            gm_x = (10'd2 * w_x * ds_x) / 10'd3;
        end else begin
            id_x = (w_x * ov_x * ov_x) / 10'd3;
            gm_x = (10'd2 * w_x * ov_x) / 10'd3;
        end
        val = id_mode ? id_x[VAL_BITS-1:0] : gm_x[VAL_BITS-1:0];
    end

endmodule

// File: rtl/smc_pipe.sv
// Pipelined transistor-array receiver: capture, per-device evaluation, sort/pick,
// then weighted sum. A valid bit rides alongside each rank.
module smc_pipe
    import smc_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [W_BITS-1:0]   W_0,
    input  logic [W_BITS-1:0]   W_1,
    input  logic [W_BITS-1:0]   W_2,
    input  logic [W_BITS-1:0]   W_3,
    input  logic [W_BITS-1:0]   W_4,
    input  logic [W_BITS-1:0]   W_5,
    input  logic [W_BITS-1:0]   V_GS_0,
    input  logic [W_BITS-1:0]   V_GS_1,
    input  logic [W_BITS-1:0]   V_GS_2,
    input  logic [W_BITS-1:0]   V_GS_3,
    input  logic [W_BITS-1:0]   V_GS_4,
    input  logic [W_BITS-1:0]   V_GS_5,
    input  logic [W_BITS-1:0]   V_DS_0,
    input  logic [W_BITS-1:0]   V_DS_1,
    input  logic [W_BITS-1:0]   V_DS_2,
    input  logic [W_BITS-1:0]   V_DS_3,
    input  logic [W_BITS-1:0]   V_DS_4,
    input  logic [W_BITS-1:0]   V_DS_5,
    input  logic [1:0]          mode,
    output logic [OUT_BITS-1:0] out_n,
    output logic                out_valid
);

    xtor_t [N_XTOR-1:0]               xtor_in, xtor_d, xtor_q;
    logic  [1:0]                      mode_d, mode_q, mode2_d, mode2_q;
    logic  [VAL_BITS-1:0]             cell_val [N_XTOR];
    logic  [N_XTOR-1:0][VAL_BITS-1:0] val2_d, val2_q;
    logic  [2:0][VAL_BITS-1:0]        pick3_d, pick3_q;
    logic                             id3_d, id3_q;
    logic  [OUT_BITS-1:0]             out_n_d, out_n_q;
    logic  [LATENCY:0]                vld_d, vld_q;
    logic  [VAL_BITS-1:0]             srt [N_XTOR];
    logic  [VAL_BITS-1:0]             tmp;

    for (genvar g = 0; g < N_XTOR; g++) begin : g_cell
        smc_cell u_cell (
            .xtor    (xtor_q[g]),
            .id_mode (mode_q[MODE_ID_BIT]),
            .val     (cell_val[g])
        );
    end

    always_comb begin
        xtor_in[0] = '{w: W_0, v_gs: V_GS_0, v_ds: V_DS_0};
        xtor_in[1] = '{w: W_1, v_gs: V_GS_1, v_ds: V_DS_1};
        xtor_in[2] = '{w: W_2, v_gs: V_GS_2, v_ds: V_DS_2};
        xtor_in[3] = '{w: W_3, v_gs: V_GS_3, v_ds: V_DS_3};
        xtor_in[4] = '{w: W_4, v_gs: V_GS_4, v_ds: V_DS_4};
        xtor_in[5] = '{w: W_5, v_gs: V_GS_5, v_ds: V_DS_5};
        xtor_d     = valid ? xtor_in : xtor_q;
        mode_d     = valid ? mode : mode_q;
        vld_d      = {vld_q[LATENCY-1:0], valid};
    end

    // Odd-even transposition network: six rounds fully sort six values descending.
    always_comb begin
        tmp = '0;
        for (int i = 0; i < N_XTOR; i++) srt[i] = val2_q[i];
        for (int r = 0; r < N_XTOR; r++) begin
            for (int i = r % 2; i < N_XTOR - 1; i += 2) begin
                if (srt[i] < srt[i+1]) begin
                    tmp      = srt[i];
                    srt[i]   = srt[i+1];
                    srt[i+1] = tmp;
                end
            end
        end
    end

    always_comb begin
        val2_d  = val2_q;
        mode2_d = mode2_q;
        if (vld_q[0]) begin
            for (int i = 0; i < N_XTOR; i++) val2_d[i] = cell_val[i];
            mode2_d = mode_q;
        end
        pick3_d = pick3_q;
        id3_d   = id3_q;
        if (vld_q[1]) begin
            if (mode2_q[MODE_LARGE_BIT]) pick3_d = {srt[2], srt[1], srt[0]};
            else                         pick3_d = {srt[5], srt[4], srt[3]};
            id3_d = mode2_q[MODE_ID_BIT];
        end
        out_n_d = '0;
        if (vld_q[2]) begin
            if (id3_q)
                out_n_d = 10'(pick3_q[0]) * 10'd3 + 10'(pick3_q[1]) * 10'd4
                        + 10'(pick3_q[2]) * 10'd5;
            else
                out_n_d = 10'(pick3_q[0]) + 10'(pick3_q[1]) + 10'(pick3_q[2]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xtor_q  <= '0;
            mode_q  <= '0;
            val2_q  <= '0;
            mode2_q <= '0;
            pick3_q <= '0;
            id3_q   <= 1'b0;
            out_n_q <= '0;
            vld_q   <= '0;
        end else begin
            xtor_q  <= xtor_d;
            mode_q  <= mode_d;
            val2_q  <= val2_d;
            mode2_q <= mode2_d;
            pick3_q <= pick3_d;
            id3_q   <= id3_d;
            out_n_q <= out_n_d;
            vld_q   <= vld_d;
        end
    end

    assign out_n     = out_n_q;
    assign out_valid = vld_q[LATENCY];

endmodule

// File: tb/tb_smc_pipe.sv
// Directed self-checking bench for smc_pipe with hand-computed expected results.
module tb_smc_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [1:0] mode;
    logic [2:0] w  [6];
    logic [2:0] gs [6];
    logic [2:0] ds [6];
    logic [9:0] out_n;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    smc_pipe #(.LATENCY(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .W_0       (w[0]),  .W_1 (w[1]),  .W_2 (w[2]),
        .W_3       (w[3]),  .W_4 (w[4]),  .W_5 (w[5]),
        .V_GS_0    (gs[0]), .V_GS_1 (gs[1]), .V_GS_2 (gs[2]),
        .V_GS_3    (gs[3]), .V_GS_4 (gs[4]), .V_GS_5 (gs[5]),
        .V_DS_0    (ds[0]), .V_DS_1 (ds[1]), .V_DS_2 (ds[2]),
        .V_DS_3    (ds[3]), .V_DS_4 (ds[4]), .V_DS_5 (ds[5]),
        .mode      (mode),
        .out_n     (out_n),
        .out_valid (out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadSet(input int which);
        case (which)
            0: for (int i = 0; i < 6; i++) begin w[i] = 3'd1; gs[i] = 3'd3; ds[i] = 3'd1; end
            1: for (int i = 0; i < 6; i++) begin w[i] = 3'd7; gs[i] = 3'd7; ds[i] = 3'd7; end
            default: begin
                w  = '{3'd3, 3'd6, 3'd1, 3'd3, 3'd2, 3'd5};
                gs = '{3'd3, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6};
                ds = '{3'd3, 3'd5, 3'd2, 3'd2, 3'd1, 3'd7};
            end
        endcase
    endtask

    task automatic scramble();
        for (int i = 0; i < 6; i++) begin
            w[i]  = 3'($urandom_range(7));
            gs[i] = 3'($urandom_range(7));
            ds[i] = 3'($urandom_range(7));
        end
        mode = 2'($urandom_range(3));
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m);
        valid = v;
        mode  = m;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic exp_v, input logic [9:0] exp_n);
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp_v);
        end
        checks++;
        assert (out_n === exp_n) else begin
            errors++;
            $error("[TB] FAIL %s out_n observed=%0d expected=%0d", tag, out_n, exp_n);
        end
    endtask

    // One isolated sample; inputs are scrambled while valid is low.
    task automatic runSingle(input string tag, input int set, input logic [1:0] m,
                             input logic [9:0] exp_n);
        loadSet(set);
        applyStimulus(1'b1, m);
        valid = 1'b0;
        scramble();
        tick();
        scramble();
        tick();
        checkOutput({tag, "_early"}, 1'b0, 10'd0);
        scramble();
        tick();
        checkOutput(tag, 1'b1, exp_n);
        scramble();
        tick();
        checkOutput({tag, "_after"}, 1'b0, 10'd0);
    endtask

    initial begin
        reset = 1'b0;
        valid = 1'b0;
        mode  = 2'd0;
        loadSet(2);
        tick();
        tick();
        checkOutput("reset", 1'b0, 10'd0);
        reset = 1'b1;
        tick();
        checkOutput("post_reset", 1'b0, 10'd0);

        runSingle("uni_id_small", 0, 2'd1, 10'd12);
        runSingle("uni_gm_small", 0, 2'd0, 10'd0);
        runSingle("sat_id_large", 1, 2'd3, 10'd1008);
        runSingle("sat_gm_large", 1, 2'd2, 10'd84);
        runSingle("mix_id_large", 2, 2'd3, 10'd255);
        runSingle("mix_id_small", 2, 2'd1, 10'd12);
        runSingle("mix_gm_large", 2, 2'd2, 10'd32);
        runSingle("mix_gm_small", 2, 2'd0, 10'd5);

        loadSet(2);
        applyStimulus(1'b1, 2'd3);
        applyStimulus(1'b1, 2'd1);
        applyStimulus(1'b1, 2'd2);
        applyStimulus(1'b1, 2'd0);
        checkOutput("b2b_0", 1'b1, 10'd255);
        applyStimulus(1'b0, 2'd0);
        checkOutput("b2b_1", 1'b1, 10'd12);
        applyStimulus(1'b0, 2'd0);
        checkOutput("b2b_2", 1'b1, 10'd32);
        applyStimulus(1'b0, 2'd0);
        checkOutput("b2b_3", 1'b1, 10'd5);
        applyStimulus(1'b0, 2'd0);
        checkOutput("b2b_end", 1'b0, 10'd0);

        applyStimulus(1'b1, 2'd3);
        applyStimulus(1'b0, 2'd3);
        applyStimulus(1'b1, 2'd2);
        applyStimulus(1'b0, 2'd0);
        checkOutput("gap_first", 1'b1, 10'd255);
        applyStimulus(1'b0, 2'd0);
        checkOutput("gap_hole", 1'b0, 10'd0);
        applyStimulus(1'b0, 2'd0);
        checkOutput("gap_second", 1'b1, 10'd32);
        applyStimulus(1'b0, 2'd0);
        checkOutput("gap_end", 1'b0, 10'd0);

        applyStimulus(1'b1, 2'd3);
        applyStimulus(1'b1, 2'd2);
        applyStimulus(1'b0, 2'd0);
        applyStimulus(1'b0, 2'd0);
        checkOutput("flight_out", 1'b1, 10'd255);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, 10'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rst_drain", 1'b0, 10'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smc_pipe.md
# smc_pipe

Pipelined DUT-side receiver for the transistor-array current/transconductance protocol. The stimulus driver in the verification environment feeds it six transistor descriptors, a mode and a `valid` strobe. Per accepted sample it computes six drain currents or transconductances, sorts them, selects the three largest or three smallest, and returns a weighted sum on `out_n`. One sample is accepted per cycle, and `out_valid` qualifies each result.

## Interface
Parameters:
- `LATENCY`, 3: cycles from `valid` sample to `out_valid`. Fixed; not user-tunable, exposed for the bench.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `valid`  input  1  sample strobe; all other inputs are meaningful only when high
- `W_0`..`W_5`  input  3 each  transistor width, 0..7
- `V_GS_0`..`V_GS_5`  input  3 each  gate-source voltage, 0..7
- `V_DS_0`..`V_DS_5`  input  3 each  drain-source voltage, 0..7
- `mode`  input  2  bit0: 1 = drain current I_D, 0 = g_m; bit1: 1 = largest three, 0 = smallest three
- `out_n`  output  10  weighted result
- `out_valid`  output  1  `out_n` is valid this cycle

## Operation
- Overdrive: ov = V_GS − 1.
- Region selection per transistor:
  - Cutoff when V_GS ≤ 1: I_D = 0, g_m = 0.
  - Triode when ov > V_DS: I_D = ⌊W·(2·ov·V_DS − V_DS²)/3⌋, g_m = ⌊2·W·V_DS/3⌋.
  - Saturation otherwise: I_D = ⌊W·ov²/3⌋, g_m = ⌊2·W·ov/3⌋.
- Value widths:
  - I_D fits 7 bits (max 84). g_m fits 5 bits (max 28).
  - Intermediates are computed unsigned at 9 bits minimum; no overflow is allowed.
  - Division truncates.
- Sort the six selected values descending: s0 ≥ s1 ≥ … ≥ s5. Ties are value-only, so order among equal values is irrelevant.
- Pick the triple: mode[1] = 1 → (n0, n1, n2) = (s0, s1, s2); mode[1] = 0 → (s3, s4, s5).
- Result:
  - I_D: out_n = 3·n0 + 4·n1 + 5·n2, max 1008.
  - g_m: out_n = n0 + n1 + n2, max 84.
- Pipeline: fully pipelined, no backpressure, no stalls, no input ready signal.
  - Stage 1: register inputs and `mode` when `valid`.
  - Stage 2: per-transistor I_D/g_m selection.
  - Stage 3: sort, pick and weighted sum into `out_n`.
- A valid bit travels with each stage. Bubbles propagate as invalid stages.
- `out_n` is forced to 0 whenever `out_valid` = 0.

## Timing
- Reset (asynchronous assert, synchronous release): `out_valid` = 0, `out_n` = 0, all stage valid bits 0, all data registers 0.
- `valid` sampled high at edge T gives `out_valid` = 1 with the result after edge T+3, for one cycle per sample.
- Back-to-back `valid` produces results on consecutive cycles in input order.
- `valid` low at T gives no result at T+3.
- Reset asserted mid-flight discards all in-flight samples. After release, `out_valid` stays 0 until a new sample completes 3 cycles later.
- Input changes while `valid` = 0 have no effect on any output.

## Structure
- Package `smc_pkg` holds:
  - Width constants: `W_BITS` = 3, `OUT_BITS` = 10, `VAL_BITS` = 7.
  - Mode bit index constants: `MODE_ID_BIT` = 0, `MODE_LARGE_BIT` = 1.
  - Constant `VTH` = 1.
  - The `xtor_t` struct {W, V_GS, V_DS}.
- Sub-module `smc_cell` is combinational: it takes one `xtor_t` plus mode[0] and returns the 7-bit selected value. It is instantiated six times in stage 2.
- The sorter (a 6-input sorting network) stays inline in `smc_pipe`.

## Test plan
- All six transistors W=1, V_GS=3, V_DS=1 (triode, I_D=1, g_m=0):
  - mode=1 → out_n=12
  - mode=0 → out_n=0
- All six transistors W=7, V_GS=7, V_DS=7 (saturation):
  - mode=3 → out_n=1008 (upper bound)
  - mode=2 → out_n=84
- Mixed set, with (W, V_GS, V_DS) = (3,3,3), (6,4,5), (1,1,2), (3,5,2), (2,2,1), (5,6,7):
  - I_D = {4, 18, 0, 12, 0, 41}, g_m = {4, 12, 0, 4, 1, 16}
  - mode 3 → 255; mode 1 → 12; mode 2 → 32; mode 0 → 5
- Mixed set applied on four consecutive cycles with mode = 3, 1, 2, 0 → `out_valid` high for four consecutive cycles starting 3 cycles later, with out_n 255, 12, 32, 5.
- `valid` pattern 1,0,1 → results appear with the same 1,0,1 spacing. `out_n` = 0 in the gap cycle.
- Two samples in flight, `reset` pulsed low → `out_valid` and `out_n` drop to 0 immediately. No result emerges after release without new `valid`.
